// File: rtl/rtc_hms_counter_pkg.sv
// Shared widths, field limits and load validation for the real-time clock counter.
// Imported by the counter top and its BCD converter.
package rtc_hms_counter_pkg;

    localparam int HH_W  = 5;
    localparam int MS_W  = 6;
    localparam int BCD_W = 8;

    localparam logic [MS_W-1:0] SEC_MAX  = 6'd59;
    localparam logic [MS_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [HH_W-1:0] HR24_MAX = 5'd23;
    localparam logic [HH_W-1:0] HR12_MAX = 5'd12;

    // A time-set is taken only if every field is a legal clock value for the mode.
    function automatic logic loadInRange(input logic            h12,
                                         input logic [HH_W-1:0] hh,
                                         input logic [MS_W-1:0] mm,
                                         input logic [MS_W-1:0] ss);
        logic hourOk;
        hourOk = h12 ? ((hh >= 5'd1) && (hh <= HR12_MAX)) : (hh <= HR24_MAX);
        return hourOk && (mm <= MIN_MAX) && (ss <= SEC_MAX);
    endfunction

endpackage

// File: rtl/rtc_hms_counter_bin2bcd.sv
// Combinational 6-bit binary to two-digit BCD split for clock fields (0..63).
// The caller registers the result.
module rtc_bin2bcd
    import rtc_hms_counter_pkg::*;
(
    input  logic [MS_W-1:0]  bin_i,
    output logic [BCD_W-1:0] bcd_o
);

    assign bcd_o = {4'(bin_i / 6'd10), 4'(bin_i % 6'd10)};

endmodule

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter driven by the 1 Hz tick: seconds/minutes/hours cascade,
// validated time-set load, registered binary and BCD fields plus rollover strobes.
module rtc_hms_counter
    import rtc_hms_counter_pkg::*;
#(
    parameter bit H12_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              run,
    input  logic              load,
    input  logic [HH_W-1:0]   ld_hh,
    input  logic [MS_W-1:0]   ld_mm,
    input  logic [MS_W-1:0]   ld_ss,
    input  logic              ld_pm,
    output logic [HH_W-1:0]   hh,
    output logic [MS_W-1:0]   mm,
    output logic [MS_W-1:0]   ss,
    output logic              pm,
    output logic [BCD_W-1:0]  hh_bcd,
    output logic [BCD_W-1:0]  mm_bcd,
    output logic [BCD_W-1:0]  ss_bcd,
    output logic              min_stb,
    output logic              hour_stb,
    output logic              day_stb,
    output logic              load_err
);

    localparam logic [HH_W-1:0]  HH_RST     = H12_MODE ? HR12_MAX : '0;
    localparam logic [BCD_W-1:0] HH_BCD_RST = H12_MODE ? 8'h12 : 8'h00;

    logic [HH_W-1:0]  hh_q, hh_d;
    logic [MS_W-1:0]  mm_q, mm_d, ss_q, ss_d;
    logic             pm_q, pm_d;
    logic             minStb_q, minStb_d, hourStb_q, hourStb_d;
    logic             dayStb_q, dayStb_d, loadErr_q, loadErr_d;
    logic [BCD_W-1:0] hhBcd_q, mmBcd_q, ssBcd_q;
    logic [BCD_W-1:0] hhBcd, mmBcd, ssBcd;
    logic             loadOk;

    // Load has priority over a coincident tick; the tick is simply dropped.
    always_comb begin
        hh_d      = hh_q;
        mm_d      = mm_q;
        ss_d      = ss_q;
        pm_d      = pm_q;
        minStb_d  = 1'b0;
        hourStb_d = 1'b0;
        dayStb_d  = 1'b0;
        loadErr_d = 1'b0;
        loadOk    = loadInRange(H12_MODE, ld_hh, ld_mm, ld_ss);

        if (load) begin
            if (loadOk) begin
                hh_d = ld_hh;
                mm_d = ld_mm;
                ss_d = ld_ss;
                pm_d = H12_MODE ? ld_pm : 1'b0;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (tick && run) begin
            if (ss_q == SEC_MAX) begin
                ss_d     = '0;
                minStb_d = 1'b1;
                if (mm_q == MIN_MAX) begin
                    mm_d      = '0;
                    hourStb_d = 1'b1;
                    // 12 h: 11->12 flips the meridiem, and only PM->AM ends the day.
                    if (H12_MODE) begin
                        if (hh_q == HR12_MAX) begin
                            hh_d = 5'd1;
                        end else if (hh_q == HR12_MAX - 5'd1) begin
                            hh_d     = HR12_MAX;
                            pm_d     = !pm_q;
                            dayStb_d = pm_q;
                        end else begin
                            hh_d = hh_q + 5'd1;
                        end
                    end else begin
                        if (hh_q == HR24_MAX) begin
                            hh_d     = '0;
                            dayStb_d = 1'b1;
                        end else begin
                            hh_d = hh_q + 5'd1;
                        end
                    end
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                ss_d = ss_q + 6'd1;
            end
        end
    end

    rtc_bin2bcd u_hhBcd (.bin_i({1'b0, hh_q}), .bcd_o(hhBcd));
    rtc_bin2bcd u_mmBcd (.bin_i(mm_q),         .bcd_o(mmBcd));
    rtc_bin2bcd u_ssBcd (.bin_i(ss_q),         .bcd_o(ssBcd));

    // BCD registers trail the binary registers by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh_q      <= HH_RST;
            mm_q      <= '0;
            ss_q      <= '0;
            pm_q      <= 1'b0;
            minStb_q  <= 1'b0;
            hourStb_q <= 1'b0;
            dayStb_q  <= 1'b0;
            loadErr_q <= 1'b0;
            hhBcd_q   <= HH_BCD_RST;
            mmBcd_q   <= '0;
            ssBcd_q   <= '0;
        end else begin
            hh_q      <= hh_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            pm_q      <= pm_d;
            minStb_q  <= minStb_d;
            hourStb_q <= hourStb_d;
            dayStb_q  <= dayStb_d;
            loadErr_q <= loadErr_d;
            hhBcd_q   <= hhBcd;
            mmBcd_q   <= mmBcd;
            ssBcd_q   <= ssBcd;
        end
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign pm       = pm_q;
    assign hh_bcd   = hhBcd_q;
    assign mm_bcd   = mmBcd_q;
    assign ss_bcd   = ssBcd_q;
    assign min_stb  = minStb_q;
    assign hour_stb = hourStb_q;
    assign day_stb  = dayStb_q;
    assign load_err = loadErr_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Bench for rtc_hms_counter: a 24 h and a 12 h instance share stimulus and are checked
// every cycle against a seconds-since-midnight reference model.
module tb_rtc_hms_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, run, load, ld_pm;
    logic [4:0] ld_hh;
    logic [5:0] ld_mm, ld_ss;

    logic [4:0] hhO[2];
    logic [5:0] mmO[2], ssO[2];
    logic       pmO[2], minO[2], hourO[2], dayO[2], errO[2];
    logic [7:0] hhBcdO[2], mmBcdO[2], ssBcdO[2];

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference state per instance (index 0 = 24 h, 1 = 12 h): seconds since midnight.
    int tSec[2], prevT[2];
    bit expMin[2], expHour[2], expDay[2], expErr[2];

    always #5 clk = ~clk;

    rtc_hms_counter #(.H12_MODE(1'b0)) dut24 (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .hh(hhO[0]), .mm(mmO[0]), .ss(ssO[0]), .pm(pmO[0]),
        .hh_bcd(hhBcdO[0]), .mm_bcd(mmBcdO[0]), .ss_bcd(ssBcdO[0]),
        .min_stb(minO[0]), .hour_stb(hourO[0]), .day_stb(dayO[0]), .load_err(errO[0])
    );

    rtc_hms_counter #(.H12_MODE(1'b1)) dut12 (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .ld_pm(ld_pm),
        .hh(hhO[1]), .mm(mmO[1]), .ss(ssO[1]), .pm(pmO[1]),
        .hh_bcd(hhBcdO[1]), .mm_bcd(mmBcdO[1]), .ss_bcd(ssBcdO[1]),
        .min_stb(minO[1]), .hour_stb(hourO[1]), .day_stb(dayO[1]), .load_err(errO[1])
    );

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
        end
    endtask

    function automatic int bcd2(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int dispHour(input int mode, input int t);
        int h24;
        h24 = t / 3600;
        if (mode == 0) return h24;
        return (h24 % 12 == 0) ? 12 : h24 % 12;
    endfunction

    function automatic logic [31:0] expBin(input int mode, input int t);
        int pmv;
        pmv = (mode == 1 && t / 3600 >= 12) ? 1 : 0;
        return {8'(dispHour(mode, t)), 8'((t / 60) % 60), 8'(t % 60), 8'(pmv)};
    endfunction

    function automatic logic [31:0] expBcd(input int mode, input int t);
        return {8'h00, 8'(bcd2(dispHour(mode, t))), 8'(bcd2((t / 60) % 60)), 8'(bcd2(t % 60))};
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            tSec[m] = 0; prevT[m] = 0;
            expMin[m] = 0; expHour[m] = 0; expDay[m] = 0; expErr[m] = 0;
        end
    endtask

    // Advance the reference by one clock edge using the currently driven inputs.
    task automatic modelStep();
        bit valid;
        int h24;
        for (int m = 0; m < 2; m++) begin
            prevT[m] = tSec[m];
            expMin[m] = 0; expHour[m] = 0; expDay[m] = 0; expErr[m] = 0;
            if (load) begin
                if (m == 0) valid = (ld_hh <= 23);
                else        valid = (ld_hh >= 1 && ld_hh <= 12);
                valid = valid && (ld_mm <= 59) && (ld_ss <= 59);
                if (valid) begin
                    h24 = (m == 0) ? int'(ld_hh) : (int'(ld_hh) % 12) + (ld_pm ? 12 : 0);
                    tSec[m] = h24 * 3600 + int'(ld_mm) * 60 + int'(ld_ss);
                end else begin
                    expErr[m] = 1;
                end
            end else if (tick && run) begin
                tSec[m]    = (tSec[m] + 1) % 86400;
                expMin[m]  = (tSec[m] % 60 == 0);
                expHour[m] = (tSec[m] % 3600 == 0);
                expDay[m]  = (tSec[m] == 0);
            end
        end
    endtask

    task automatic checkAll();
        for (int m = 0; m < 2; m++) begin
            string sfx;
            sfx = (m == 0) ? "24" : "12";
            checkOutput({"bin", sfx}, {3'b0, hhO[m], 2'b0, mmO[m], 2'b0, ssO[m], 7'b0, pmO[m]}, expBin(m, tSec[m]));
            checkOutput({"bcd", sfx}, {8'h00, hhBcdO[m], mmBcdO[m], ssBcdO[m]}, expBcd(m, prevT[m]));
            checkOutput({"stb", sfx}, {28'b0, minO[m], hourO[m], dayO[m], errO[m]},
                        {28'b0, expMin[m], expHour[m], expDay[m], expErr[m]});
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, step the model, check at negedge.
    task automatic applyStimulus(input logic t, input logic r, input logic l,
                                 input logic [4:0] h, input logic [5:0] mn, input logic [5:0] s, input logic p);
        tick = t; run = r; load = l; ld_hh = h; ld_mm = mn; ld_ss = s; ld_pm = p;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll();
        tick = 1'b0; load = 1'b0;
    endtask

    // Asynchronous reset in mid-cycle; outputs must return to reset values before any edge.
    task automatic pulseReset();
        #2 reset = 1'b1;
        modelReset();
        #1 checkAll();
        @(negedge clk);
        checkAll();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 0; run = 1; load = 0; ld_hh = 0; ld_mm = 0; ld_ss = 0; ld_pm = 0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll();
        reset = 1'b0;

        // Full minute of ticks, then one more cycle to see the trailing BCD
        for (int i = 0; i < 60; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // End-of-day rollover and 12 h meridiem boundaries
        applyStimulus(0, 1, 1, 23, 59, 59, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 11, 59, 59, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 11, 59, 59, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 12, 59, 59, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Out-of-range loads, then load colliding with tick
        applyStimulus(0, 1, 1, 5, 60, 10, 0);
        applyStimulus(0, 1, 1, 0, 30, 30, 0);
        applyStimulus(0, 1, 1, 10, 20, 30, 0);
        applyStimulus(1, 1, 1, 10, 20, 30, 0);
        applyStimulus(1, 1, 1, 10, 63, 30, 0);

        // Held run=0 ignores ticks; tick held high counts every cycle
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
        pulseReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Randomized traffic, biased toward near-rollover loads
        for (int i = 0; i < 3000; i++) begin
            logic       t, r, l, p;
            logic [4:0] h;
            logic [5:0] mn, s;
            t  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 7) != 0);
            l  = ($urandom_range(0, 15) == 0);
            p  = 1'(($urandom_range(0, 1)));
            h  = 5'($urandom_range(0, 25));
            mn = 6'($urandom_range(0, 62));
            s  = 6'($urandom_range(0, 62));
            if ($urandom_range(0, 1) == 1) begin
                h  = ($urandom_range(0, 1) == 1) ? 5'd11 : 5'($urandom_range(0, 1) == 1 ? 23 : 12);
                mn = 6'd59;
                s  = 6'($urandom_range(55, 59));
            end
            if ($urandom_range(0, 499) == 0) pulseReset();
            else applyStimulus(t, r, l, h, mn, s, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
